// File: rtl/ps2_kbd_68k_pkg.sv
// Shared definitions for the PS/2 keyboard peripheral: register map,
// CONTROL bit positions and key-event width.
package kbd_pkg;

    localparam int unsigned EVT_W = 10;

    typedef enum logic [1:0] {
        KBD_DATA   = 2'd0,
        KBD_STATUS = 2'd1,
        KBD_CTRL   = 2'd2,
        KBD_RSVD   = 2'd3
    } kbd_reg_e;

    localparam int unsigned CTRL_IRQ_EN  = 0;
    localparam int unsigned CTRL_FLUSH   = 1;
    localparam int unsigned CTRL_CLR_OVF = 2;

    function automatic logic [15:0] status_word(input logic       not_empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [7:0] count);
        return {count, 5'b0, ovf, full, not_empty};
    endfunction

endpackage

// File: rtl/ps2_kbd_68k_if.sv
// 68k bus slice seen by the keyboard peripheral, plus its interrupt outputs.
interface ps2_kbd_68k_if;
    logic        cs;
    logic        as_n;
    logic        rw;
    logic        lds_n;
    logic [1:0]  addr;
    logic [7:0]  din;
    logic [15:0] dout;
    logic [2:0]  ipl_n;
    logic        irq;

    modport master (output cs, as_n, rw, lds_n, addr, din,
                    input  dout, ipl_n, irq);
    modport slave  (input  cs, as_n, rw, lds_n, addr, din,
                    output dout, ipl_n, irq);
endinterface

// File: rtl/ps2_kbd_68k_fifo.sv
// Synchronous FIFO with flush; a push while full is accepted only when a
// same-cycle pop frees the slot, otherwise it is dropped and reported.
module sync_fifo #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    input  logic [WIDTH-1:0]      wdata_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  drop_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign drop_o  = push_i & ~push_ok & ~flush_i;

    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_kbd_68k.sv
// PS/2 keyboard peripheral for the 68000 bus: captures key events into a
// FIFO and exposes DATA/STATUS/CONTROL registers with an optional level IRQ.
module ps2_kbd_68k
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter logic [2:0]  IRQ_LEVEL  = 3'd2
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [10:0]    ps2_key,
    ps2_kbd_68k_if.slave   bus
);
    logic                tog_q, armed_q;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [2:0]          wdat_q;
    logic                irq_en_q, ovf_q;

    logic                evt, pop, wr_fire, flush;
    logic [EVT_W-1:0]    fifo_rdata;
    logic                fifo_full, fifo_empty, fifo_drop;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                irq;
    logic                unused_din;

    assign unused_din = ^bus.din[7:3];

    // armed_q keeps the first post-reset sample from looking like a toggle
    assign evt = armed_q & (tog_q ^ ps2_key[10]);

    assign rd_d = bus.cs & bus.rw & ~bus.as_n & (bus.addr == KBD_DATA);
    assign wr_d = bus.cs & ~bus.rw & ~bus.as_n & ~bus.lds_n & (bus.addr == KBD_CTRL);

    // Both actions fire on the as_n rising edge that ends the bus cycle
    assign pop     = rd_q & bus.as_n;
    assign wr_fire = wr_q & bus.as_n;
    assign flush   = wr_fire & wdat_q[CTRL_FLUSH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            armed_q  <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdat_q   <= '0;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            tog_q   <= ps2_key[10];
            armed_q <= 1'b1;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if (wr_d) wdat_q <= bus.din[2:0];
            if (wr_fire) irq_en_q <= wdat_q[CTRL_IRQ_EN];
            if (wr_fire && wdat_q[CTRL_CLR_OVF]) ovf_q <= 1'b0;
            else if (fifo_drop)                  ovf_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH      (EVT_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (evt),
        .pop_i   (pop),
        .flush_i (flush),
        .wdata_i (ps2_key[9:0]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count),
        .drop_o  (fifo_drop)
    );

    always_comb begin
        bus.dout = '0;
        if (bus.cs && !bus.as_n) begin
            case (bus.addr)
                KBD_DATA:   bus.dout = fifo_empty ? '0 : {1'b1, 5'b0, fifo_rdata};
                KBD_STATUS: bus.dout = status_word(~fifo_empty, fifo_full, ovf_q,
                                                   8'(fifo_count));
                KBD_CTRL:   bus.dout = {15'b0, irq_en_q};
                default:    bus.dout = '0;
            endcase
        end
    end

    assign irq       = irq_en_q & ~fifo_empty;
    assign bus.irq   = irq;
    assign bus.ipl_n = irq ? ~IRQ_LEVEL : 3'b111;

endmodule

// File: tb/tb_ps2_kbd_68k.sv
// Scoreboard bench for ps2_kbd_68k: stimulus queues expected bus reads and
// pin probes; independent monitors pop and compare.
module tb_ps2_kbd_68k;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;

    ps2_kbd_68k_if bif ();

    ps2_kbd_68k #(
        .DEPTH_LOG2 (4),
        .IRQ_LEVEL  (3'd2)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .bus     (bif)
    );

    always #20 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] exp;
        bit          pins;
    } sb_t;

    sb_t  sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   in_cyc = 1'b0;
    event probe_ev;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic consume(input bit pins, input logic [15:0] act);
        sb_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h, expected nothing", act);
        end else begin
            e = sb.pop_front();
            if (e.pins != pins) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: output kind %0d, expected kind %0d", e.name, pins, e.pins);
            end else begin
                check(e.name, act, e.exp);
            end
        end
    endtask

    // Bus monitor: one sample per read bus cycle, mid-cycle on the falling edge
    always @(negedge clk) begin
        if (bif.cs && !bif.as_n && bif.rw) begin
            if (!in_cyc) begin
                in_cyc = 1'b1;
                consume(1'b0, bif.dout);
            end
        end else if (bif.as_n) begin
            in_cyc = 1'b0;
        end
    end

    always @(probe_ev) consume(1'b1, {12'b0, bif.irq, bif.ipl_n});

    task automatic key_evt(input logic [9:0] evd);
        @(posedge clk); #1;
        ps2_key = {~ps2_key[10], evd};
    endtask

    task automatic bus_read(input string name, input logic [1:0] a, input logic [15:0] exp,
                            input bit ev = 1'b0, input logic [9:0] evd = '0);
        sb.push_back('{name, exp, 1'b0});
        @(posedge clk); #1;
        bif.cs = 1'b1; bif.rw = 1'b1; bif.as_n = 1'b0; bif.addr = a;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bif.as_n = 1'b1; bif.cs = 1'b0;
        if (ev) ps2_key = {~ps2_key[10], evd};
        @(posedge clk); #1;
    endtask

    task automatic bus_write(input logic [7:0] d, input bit ev = 1'b0, input logic [9:0] evd = '0);
        @(posedge clk); #1;
        bif.cs = 1'b1; bif.rw = 1'b0; bif.lds_n = 1'b0; bif.as_n = 1'b0;
        bif.addr = 2'd2; bif.din = d;
        @(posedge clk); #1;
        bif.as_n = 1'b1; bif.cs = 1'b0; bif.lds_n = 1'b1; bif.rw = 1'b1;
        if (ev) ps2_key = {~ps2_key[10], evd};
        @(posedge clk); #1;
    endtask

    task automatic probe(input string name, input logic [15:0] exp, input bit sync = 1'b1);
        sb.push_back('{name, exp, 1'b1});
        if (sync) @(posedge clk);
        @(negedge clk);
        -> probe_ev;
    endtask

    initial begin
        logic [15:0] exp_q[$];
        logic [7:0]  c;

        reset_n = 1'b0;
        ps2_key = 11'h400;
        bif.cs = 1'b0; bif.as_n = 1'b1; bif.rw = 1'b1; bif.lds_n = 1'b1;
        bif.addr = 2'd0; bif.din = 8'h00;

        probe("rst_pins", 16'h0007, 1'b0);
        bus_read("rst_status", 2'd1, 16'h0000);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        bus_read("post_rst_status", 2'd1, 16'h0000);
        bus_read("post_rst_ctrl", 2'd2, 16'h0000);

        // single event
        key_evt({1'b1, 1'b0, 8'h1C});
        bus_read("single_status", 2'd1, 16'h0101);
        bus_read("single_data", 2'd0, 16'h821C);
        bus_read("single_status_after", 2'd1, 16'h0000);
        bus_read("reg3_read", 2'd3, 16'h0000);
        bus_read("data_empty", 2'd0, 16'h0000);

        // ordering and pointer wrap, events on back-to-back cycles
        for (int i = 0; i < 20; i++) begin
            c = 8'(i);
            key_evt({c[0], 1'b0, c});
            exp_q.push_back(16'h8000 | (16'(c[0]) << 9) | 16'(c));
            if (i % 3 == 2)
                for (int k = 0; k < 3; k++) bus_read("wrap_data", 2'd0, exp_q.pop_front());
        end
        while (exp_q.size() > 0) bus_read("wrap_data", 2'd0, exp_q.pop_front());
        bus_read("wrap_status", 2'd1, 16'h0000);

        // overflow
        for (int i = 0; i < 17; i++) key_evt({2'b10, 8'(8'h40 + i)});
        bus_read("ovf_status", 2'd1, 16'h1007);
        bus_write(8'h04);
        bus_read("ovf_cleared", 2'd1, 16'h1003);
        for (int i = 0; i < 16; i++) bus_read("ovf_data", 2'd0, 16'h8240 + 16'(i));
        bus_read("ovf_drained", 2'd1, 16'h0000);

        // interrupt
        key_evt({2'b01, 8'h5A});
        bus_write(8'h01);
        probe("irq_on", 16'h000D);
        bus_read("irq_ctrl", 2'd2, 16'h0001);
        bus_read("irq_data", 2'd0, 16'h815A);
        probe("irq_off_after_pop", 16'h0007);
        key_evt({2'b11, 8'h75});
        probe("irq_on_again", 16'h000D);
        bus_write(8'h00);
        probe("irq_disabled", 16'h0007);
        bus_read("irq_data2", 2'd0, 16'h8375);

        // push with pop on empty FIFO
        bus_read("sim_empty_data", 2'd0, 16'h0000, 1'b1, {2'b10, 8'h29});
        bus_read("sim_empty_status", 2'd1, 16'h0101);
        bus_read("sim_empty_data2", 2'd0, 16'h8229);

        // push with pop at count 5, then flush
        for (int i = 0; i < 5; i++) key_evt({2'b00, 8'(8'h30 + i)});
        bus_read("sim5_data", 2'd0, 16'h8030, 1'b1, {2'b00, 8'h35});
        bus_read("sim5_status", 2'd1, 16'h0501);
        bus_write(8'h02);
        bus_read("flush_status", 2'd1, 16'h0000);

        // push while full with same-cycle pop
        for (int i = 0; i < 16; i++) key_evt({2'b00, 8'(8'h50 + i)});
        bus_read("full_status", 2'd1, 16'h1003);
        bus_read("full_pop_data", 2'd0, 16'h8050, 1'b1, {2'b00, 8'h60});
        bus_read("full_pop_status", 2'd1, 16'h1003);
        for (int i = 1; i < 16; i++) bus_read("full_data", 2'd0, 16'h8050 + 16'(i));
        bus_read("full_data_last", 2'd0, 16'h8060);

        // flush with simultaneous push
        key_evt({2'b00, 8'h11});
        bus_write(8'h02, 1'b1, {2'b00, 8'h12});
        bus_read("flush_push_status", 2'd1, 16'h0000);

        // reset mid-operation
        for (int i = 0; i < 4; i++) key_evt({2'b10, 8'(8'h70 + i)});
        bus_write(8'h01);
        probe("pre_rst_irq", 16'h000D);
        @(posedge clk); #1 reset_n = 1'b0;
        probe("mid_rst_pins", 16'h0007, 1'b0);
        bus_read("mid_rst_status", 2'd1, 16'h0000);
        bus_read("mid_rst_data", 2'd0, 16'h0000);
        bus_read("mid_rst_ctrl", 2'd2, 16'h0000);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        bus_read("rel_status", 2'd1, 16'h0000);
        probe("rel_pins", 16'h0007);
        key_evt({2'b10, 8'h1C});
        bus_read("rel_evt_status", 2'd1, 16'h0101);
        bus_read("rel_evt_data", 2'd0, 16'h821C);

        for (int t = 0; t < 50 && sb.size() > 0; t++) @(posedge clk);
        while (sb.size() > 0) begin
            sb_t e;
            e = sb.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: no output observed, expected %h", e.name, e.exp);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
